// File: rtl/display_arbiter.sv
// Round-robin owner arbiter for the shared 8-digit seven-segment display, with a minimum hold time.
// Optional blank interval between owners when DISPLAY_ARB_GAP_EN is defined.
module display_arbiter #(
    parameter int N_REQ       = 3,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 5_000_000
) (
    input  logic                 CLK100MHZ,
    input  logic                 reset_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [32*N_REQ-1:0]  data_i,
    output logic [N_REQ-1:0]     grant,
    output logic                 owner_valid,
    output logic [6:0]           CA7,
    output logic [6:0]           CA6,
    output logic [6:0]           CA5,
    output logic [6:0]           CA4,
    output logic [6:0]           CA3,
    output logic [6:0]           CA2,
    output logic [6:0]           CA1,
    output logic [6:0]           CA0
);

    localparam int IW = (N_REQ > 2) ? 2 : 1;
    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES);

`ifdef DISPLAY_ARB_GAP_EN
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 1) ? GW'(GAP_CYCLES - 1) : '0;
    typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, OWN} state_t;
`endif

    state_t          state, state_n;
    logic [N_REQ-1:0] grant_n;
    logic [IW-1:0]   last_owner, last_n;
    logic [CW-1:0]   hold_cnt, hold_n;
`ifdef DISPLAY_ARB_GAP_EN
    logic [GW-1:0]   gap_cnt, gap_n;
`endif
    logic [N_REQ-1:0] others;
    logic [IW-1:0]   pick_any, pick_other;
    logic [31:0]     owner_data;
    logic [6:0]      ca_q [8];

    // First set bit of cand searching upward from base+1 with wrap-around.
    function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] cand, input logic [IW-1:0] base);
        logic [IW-1:0] sel;
        logic          found;
        int            idx;
        sel   = '0;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(base) + i) % N_REQ;
            if (!found && cand[idx]) begin
                found = 1'b1;
                sel   = IW'(idx);
            end
        end
        return sel;
    endfunction

    function automatic logic [N_REQ-1:0] to_onehot(input logic [IW-1:0] idx);
        logic [N_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    assign others     = req & ~grant;
    assign pick_any   = rr_pick(req, last_owner);
    assign pick_other = rr_pick(others, last_owner);

    always_comb begin
        state_n = state;
        grant_n = grant;
        last_n  = last_owner;
        hold_n  = hold_cnt;
`ifdef DISPLAY_ARB_GAP_EN
        gap_n   = gap_cnt;
`endif
        case (state)
            IDLE: begin
                if (|req) begin
                    grant_n = to_onehot(pick_any);
                    last_n  = pick_any;
                    hold_n  = '0;
                    state_n = OWN;
                end
            end
            OWN: begin
                // A dropped request wins over hold expiry; both release the display.
                if (!req[last_owner] || (hold_cnt == HOLD_MAX && |others)) begin
`ifdef DISPLAY_ARB_GAP_EN
                    grant_n = '0;
                    gap_n   = '0;
                    state_n = GAP;
`else
                    if (|others) begin
                        grant_n = to_onehot(pick_other);
                        last_n  = pick_other;
                        hold_n  = '0;
                    end else begin
                        grant_n = '0;
                        state_n = IDLE;
                    end
`endif
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
`ifdef DISPLAY_ARB_GAP_EN
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    if (|req) begin
                        grant_n = to_onehot(pick_any);
                        last_n  = pick_any;
                        hold_n  = '0;
                        state_n = OWN;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    gap_n = gap_cnt + 1'b1;
                end
            end
`endif
            default: begin
                grant_n = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant      <= '0;
            last_owner <= IW'(N_REQ - 1);
            hold_cnt   <= '0;
`ifdef DISPLAY_ARB_GAP_EN
            gap_cnt    <= '0;
`endif
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            last_owner <= last_n;
            hold_cnt   <= hold_n;
`ifdef DISPLAY_ARB_GAP_EN
            gap_cnt    <= gap_n;
`endif
        end
    end

    always_comb begin
        owner_data = data_i[31:0];
        for (int r = 0; r < N_REQ; r++) begin
            if (IW'(r) == last_owner) owner_data = data_i[32*r +: 32];
        end
    end

    // Segment outputs are registered so nothing from req or data_i reaches a pin combinationally.
    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 8; k++) ca_q[k] <= 7'h7F;
        end else begin
            for (int k = 0; k < 8; k++) ca_q[k] <= (|grant) ? seg_decode(owner_data[4*k +: 4]) : 7'h7F;
        end
    end

    assign owner_valid = |grant;
    assign CA0 = ca_q[0];
    assign CA1 = ca_q[1];
    assign CA2 = ca_q[2];
    assign CA3 = ca_q[3];
    assign CA4 = ca_q[4];
    assign CA5 = ca_q[5];
    assign CA6 = ca_q[6];
    assign CA7 = ca_q[7];

endmodule

// File: tb/tb_display_arbiter.sv
// Directed self-checking bench for display_arbiter (N_REQ=3, HOLD_CYCLES=4, GAP_CYCLES=3).
module tb_display_arbiter;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic        clk;
    logic        reset_n;
    logic [2:0]  req;
    logic [95:0] data;
    logic [2:0]  grant;
    logic        owner_valid;
    logic [6:0]  ca_obs [8];
    int          checks;
    int          errors;

    display_arbiter #(.N_REQ(3), .HOLD_CYCLES(4), .GAP_CYCLES(3)) dut (
        .CLK100MHZ   (clk),
        .reset_n     (reset_n),
        .req         (req),
        .data_i      (data),
        .grant       (grant),
        .owner_valid (owner_valid),
        .CA7         (ca_obs[7]),
        .CA6         (ca_obs[6]),
        .CA5         (ca_obs[5]),
        .CA4         (ca_obs[4]),
        .CA3         (ca_obs[3]),
        .CA2         (ca_obs[2]),
        .CA1         (ca_obs[1]),
        .CA0         (ca_obs[0])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] r, input logic [95:0] d);
        req  = r;
        data = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [55:0] exp_ca(input logic [31:0] w);
        logic [55:0] v;
        for (int k = 0; k < 8; k++) v[7*k +: 7] = SEG_TAB[w[4*k +: 4]];
        return v;
    endfunction

    task automatic checkCa(input string tag, input logic [55:0] expected);
        for (int k = 0; k < 8; k++)
            checkOutput($sformatf("%s_CA%0d", tag, k), {25'd0, ca_obs[k]}, {25'd0, expected[7*k +: 7]});
    endtask

    task automatic checkGrant(input string tag, input logic [2:0] expected);
        checkOutput({tag, "_grant"}, {29'd0, grant}, {29'd0, expected});
        checkOutput({tag, "_valid"}, {31'd0, owner_valid}, {31'd0, |expected});
    endtask

    task automatic applyReset();
        applyStimulus(3'b000, '0);
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    localparam logic [55:0] BLANK = {8{7'h7F}};

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        applyStimulus(3'b000, '0);
        step();
        step();
        checkGrant("reset", 3'b000);
        checkCa("reset", BLANK);

        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checkGrant($sformatf("idle%0d", i), 3'b000);
        end
        checkCa("idle", BLANK);

        applyStimulus(3'b110, {32'h0, 32'h0123_89AF, 32'h0});
        step();
        checkGrant("first", 3'b010);
        step();
        checkCa("first", exp_ca(32'h0123_89AF));
        checkOutput("first_CA0_F", {25'd0, ca_obs[0]}, {25'd0, 7'b0111000});
        applyStimulus(3'b110, {32'h0, 32'h4567_BCDE, 32'h0});
        step();
        checkCa("datachg", exp_ca(32'h4567_BCDE));
        checkGrant("datachg", 3'b010);
        applyStimulus(3'b000, {32'h0, 32'h4567_BCDE, 32'h0});
        step();
        checkGrant("alldrop", 3'b000);
        step();
        checkCa("alldrop", BLANK);

`ifndef DISPLAY_ARB_GAP_EN
        applyStimulus(3'b011, '0);
        step();
        checkGrant("hold0_g", 3'b001);
        for (int i = 1; i <= 4; i++) begin
            step();
            checkGrant($sformatf("hold0_%0d", i), 3'b001);
        end
        step();
        checkGrant("hold0_hand", 3'b010);
        for (int i = 1; i <= 4; i++) begin
            step();
            checkGrant($sformatf("hold1_%0d", i), 3'b010);
        end
        step();
        checkGrant("hold1_wrap", 3'b001);

        applyStimulus(3'b101, {32'hFFFF_FFFF, 32'h0, 32'h0});
        for (int i = 1; i <= 4; i++) begin
            step();
            checkGrant($sformatf("pre2_%0d", i), 3'b001);
        end
        step();
        checkGrant("own2", 3'b100);
        step();
        checkGrant("own2_c1", 3'b100);
        checkCa("own2", exp_ca(32'hFFFF_FFFF));
        applyStimulus(3'b001, {32'hFFFF_FFFF, 32'h0, 32'h0});
        step();
        checkGrant("drop2", 3'b001);
        step();
        checkCa("drop2", exp_ca(32'h0));
        applyStimulus(3'b000, '0);
        step();
        checkGrant("drop_all", 3'b000);
        step();
        checkCa("drop_all", BLANK);
`else
        applyReset();
        applyStimulus(3'b110, '0);
        step();
        checkGrant("gap_own1", 3'b010);
        for (int i = 1; i <= 4; i++) begin
            step();
            checkGrant($sformatf("gap_hold%0d", i), 3'b010);
        end
        step();
        checkGrant("gap_c1", 3'b000);
        step();
        checkGrant("gap_c2", 3'b000);
        checkCa("gap_c2", BLANK);
        step();
        checkGrant("gap_c3", 3'b000);
        checkCa("gap_c3", BLANK);
        step();
        checkGrant("gap_exit", 3'b100);
        checkCa("gap_exit", BLANK);
`endif

        applyReset();
        applyStimulus(3'b001, {32'h0, 32'h0, 32'h1234_5678});
        step();
        checkGrant("ar_own0", 3'b001);
        step();
        checkCa("ar_own0", exp_ca(32'h1234_5678));
        #3;
        reset_n = 1'b0;
        #1;
        checkGrant("ar_async", 3'b000);
        checkCa("ar_async", BLANK);
        applyStimulus(3'b111, {32'h0, 32'h0, 32'h1234_5678});
        step();
        step();
        checkGrant("ar_held", 3'b000);
        reset_n = 1'b1;
        step();
        checkGrant("ar_restart", 3'b001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
